// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and data memory.
// Circular FIFO with valid/ready drain and youngest-match store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memwrite,
  input  logic [AW-1:0]                dataadr,
  input  logic [DW-1:0]                writedata,
  input  logic [AW-1:0]                readaddr,
  output logic                         fwd_hit,
  output logic [DW-1:0]                fwd_data,
  output logic                         stall,
  output logic                         mem_valid,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  input  logic                         mem_ready,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-3:0]    adr_q [DEPTH];
  logic [DW-1:0]    dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, enq, deq;
  logic [PW-1:0]    idx;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign mem_valid = ~empty;
  assign stall     = memwrite & full;
  assign enq       = memwrite & ~full;
  assign deq       = mem_valid & mem_ready;
  assign mem_addr  = {adr_q[rd_q], 2'b00};
  assign mem_wdata = dat_q[rd_q];

  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (deq) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + PW'(1);
    end
    if (enq) begin
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + PW'(1);
    end
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_q - PW'(k);
      if (vld_q[idx] && (adr_q[idx] == readaddr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = dat_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      if (enq) begin
        adr_q[wr_q] <= dataadr[AW-1:2];
        dat_q[wr_q] <= writedata;
      end
    end
  end

endmodule
